// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: SPI mode-0 slave that turns command/address/data frames
// into 2-cycle peripheral-bus accesses after a CPU halt handshake.
// Ports:
//   clk_i, rst_n             : clock, synchronous active-low reset
//   sck_i, cs_n_i, mosi_i    : async SPI slave inputs
//   miso_o, miso_oe          : serial read data and its output enable
//   halt_req, halt_ack       : CPU bus release handshake
//   bus_cyc/we/addr/data_out : bus initiator, bus_sel one-hot target
//   bus_in_*                 : read data from gpios/timers/serial/sid
// Option: define SPI_BUS_BRIDGE_TIMEOUT_EN for the halt-ack timeout.
module spi_bus_bridge #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe,
  output logic       halt_req,
  input  logic       halt_ack,
  output logic       bus_cyc,
  output logic       bus_we,
  output logic [5:0] bus_addr,
  output logic [7:0] bus_data_out,
  output logic [3:0] bus_sel,
  input  logic [7:0] bus_in_gpios,
  input  logic [7:0] bus_in_timers,
  input  logic [7:0] bus_in_serial_ports,
  input  logic [7:0] bus_in_sid
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, ARB, CYC, DATA
  } state_e;

  state_e state_q;

  logic [SYNC_STAGES-1:0] sck_sq;
  logic [SYNC_STAGES-1:0] cs_sq;
  logic [SYNC_STAGES-1:0] mosi_sq;
  logic       sck_prev_q;
  logic [2:0] bit_q;
  logic [6:0] rx_q;
  logic [7:0] tx_q;
  logic [7:0] wdata_q;
  logic       w_q;
  logic [1:0] sel_q;
  logic [5:0] addr_q;
  logic       cyc2_q;
  logic       halt_q;
  logic       cyc_q;
  logic       we_q;
  logic       oe_q;
  logic [7:0] dout_q;
  logic [3:0] bsel_q;

`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt_q;
  logic          to_flag_q;
`endif

  logic       sck_s;
  logic       cs_s;
  logic       mosi_s;
  logic       rise;
  logic       fall;
  logic [7:0] rx_d;
  logic [7:0] rdata;

  assign sck_s  = sck_sq[SYNC_STAGES-1];
  assign cs_s   = cs_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;
  assign rx_d   = {rx_q, mosi_s};

  always_comb begin
    rdata = bus_in_gpios;
    unique case (1'b1)
      bsel_q[1]: rdata = bus_in_timers;
      bsel_q[2]: rdata = bus_in_serial_ports;
      bsel_q[3]: rdata = bus_in_sid;
      default:   rdata = bus_in_gpios;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sck_sq     <= '0;
      cs_sq      <= '1;
      mosi_sq    <= '0;
      sck_prev_q <= 1'b0;
      state_q    <= IDLE;
      bit_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      wdata_q    <= '0;
      w_q        <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      cyc2_q     <= 1'b0;
      halt_q     <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      bsel_q     <= '0;
`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
`endif
    end else begin
      sck_sq     <= {sck_sq[SYNC_STAGES-2:0], sck_i};
      cs_sq      <= {cs_sq[SYNC_STAGES-2:0], cs_n_i};
      mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q <= sck_s;
      oe_q       <= ~cs_s;
`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          halt_q <= 1'b0;
          bit_q  <= '0;
          tx_q   <= '0;
          if (!cs_s) state_q <= CMD;
        end
        CMD, ADDR, DATA: begin
          if (cs_s) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
          end else if (rise) begin
            rx_q  <= rx_d[6:0];
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (state_q == CMD) begin
                w_q     <= rx_d[7];
                sel_q   <= rx_d[1:0];
                bsel_q  <= 4'b0001 << rx_d[1:0];
                state_q <= ADDR;
              end else if (state_q == ADDR) begin
                addr_q  <= rx_d[5:0];
                state_q <= w_q ? DATA : ARB;
              end else begin
                // reads prefetch the next address
                if (w_q) wdata_q <= rx_d;
                else     addr_q  <= addr_q + 6'd1;
                state_q <= ARB;
              end
            end
          end else if (fall && state_q == DATA && bit_q != 3'd0) begin
            // the fall after bit 8 would clobber a fresh preload
            tx_q <= {tx_q[6:0], 1'b0};
          end
        end
        ARB: begin
          halt_q <= 1'b1;
          if (cs_s) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
          end else if (halt_q && halt_ack) begin
            state_q <= CYC;
            cyc_q   <= 1'b1;
            we_q    <= w_q;
            dout_q  <= w_q ? wdata_q : 8'h00;
            cyc2_q  <= 1'b0;
          end
`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
          else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_flag_q <= 1'b1;
            if (w_q) addr_q <= addr_q + 6'd1;
            else     tx_q   <= 8'hFF;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        CYC: begin
          if (!cyc2_q) begin
            cyc2_q <= 1'b1;
          end else begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            dout_q <= 8'h00;
            bit_q  <= '0;
            if (w_q) addr_q <= addr_q + 6'd1;
            else     tx_q   <= rdata;
`ifdef SPI_BUS_BRIDGE_TIMEOUT_EN
            if (!w_q && sel_q == 2'd0 && addr_q == 6'h3F)
              to_flag_q <= 1'b0;
`endif
            if (cs_s) begin
              state_q <= IDLE;
              halt_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso_o       = tx_q[7];
  assign miso_oe      = oe_q;
  assign halt_req     = halt_q;
  assign bus_cyc      = cyc_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_data_out = dout_q;
  assign bus_sel      = bsel_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb_spi_bus_bridge: random and directed SPI frames against a
// frame-level model of expected bus cycles and MISO bytes.
module tb_spi_bus_bridge;

  logic       clk_i  = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sck_i  = 1'b0;
  logic       cs_n_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       miso_o;
  logic       miso_oe;
  logic       halt_req;
  logic       halt_ack;
  logic       bus_cyc;
  logic       bus_we;
  logic [5:0] bus_addr;
  logic [7:0] bus_data_out;
  logic [3:0] bus_sel;
  logic [7:0] bus_in_gpios;
  logic [7:0] bus_in_timers;
  logic [7:0] bus_in_serial_ports;
  logic [7:0] bus_in_sid;

  logic [7:0] mem [4][64];
  logic [7:0] fd [4];
  int n_tot = 0;
  int n_bad = 0;
  int viol  = 0;
  int hcnt  = 0;
  bit ack_dly = 1'b0;

  spi_bus_bridge dut (
    .clk_i               (clk_i),
    .rst_n               (rst_n),
    .sck_i               (sck_i),
    .cs_n_i              (cs_n_i),
    .mosi_i              (mosi_i),
    .miso_o              (miso_o),
    .miso_oe             (miso_oe),
    .halt_req            (halt_req),
    .halt_ack            (halt_ack),
    .bus_cyc             (bus_cyc),
    .bus_we              (bus_we),
    .bus_addr            (bus_addr),
    .bus_data_out        (bus_data_out),
    .bus_sel             (bus_sel),
    .bus_in_gpios        (bus_in_gpios),
    .bus_in_timers       (bus_in_timers),
    .bus_in_serial_ports (bus_in_serial_ports),
    .bus_in_sid          (bus_in_sid)
  );

  always #5 clk_i = ~clk_i;

  assign bus_in_gpios        = mem[0][bus_addr];
  assign bus_in_timers       = mem[1][bus_addr];
  assign bus_in_serial_ports = mem[2][bus_addr];
  assign bus_in_sid          = mem[3][bus_addr];

  // CPU model: optionally acks only after 20 cycles of halt_req
  assign halt_ack = ack_dly ? (hcnt >= 20) : 1'b1;
  always @(posedge clk_i) hcnt <= halt_req ? hcnt + 1 : 0;

  // bus cycle recorder
  logic [5:0] q_addr [$];
  logic [3:0] q_sel  [$];
  logic       q_we   [$];
  logic [7:0] q_data [$];
  int         q_len  [$];
  bit         q_stab [$];
  int         q_h    [$];
  bit         in_cyc;
  logic [5:0] c_addr;
  logic [3:0] c_sel;
  logic       c_we;
  logic [7:0] c_data;
  int         c_len;
  int         c_h;
  bit         c_stab;

  initial begin
    in_cyc = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bus_cyc) begin
        if (!in_cyc) begin
          c_addr = bus_addr;
          c_sel  = bus_sel;
          c_we   = bus_we;
          c_data = bus_data_out;
          c_len  = 0;
          c_stab = 1'b1;
          c_h    = hcnt;
        end else if (bus_addr !== c_addr || bus_sel !== c_sel ||
                     bus_we !== c_we || bus_data_out !== c_data) begin
          c_stab = 1'b0;
        end
        c_len++;
        in_cyc = 1'b1;
        if (!halt_ack || !halt_req) viol++;
      end else begin
        if (in_cyc) begin
          q_addr.push_back(c_addr);
          q_sel.push_back(c_sel);
          q_we.push_back(c_we);
          q_data.push_back(c_data);
          q_len.push_back(c_len);
          q_stab.push_back(c_stab);
          q_h.push_back(c_h);
        end
        in_cyc = 1'b0;
        if (bus_we || bus_data_out != 8'h00) viol++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    q_addr.delete();
    q_sel.delete();
    q_we.delete();
    q_data.delete();
    q_len.delete();
    q_stab.delete();
    q_h.delete();
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_miso"}, miso_o, 0);
    chk({t, "_oe"}, miso_oe, 0);
    chk({t, "_halt"}, halt_req, 0);
    chk({t, "_cyc"}, bus_cyc, 0);
    chk({t, "_we"}, bus_we, 0);
    chk({t, "_addr"}, bus_addr, 0);
    chk({t, "_dout"}, bus_data_out, 0);
    chk({t, "_sel"}, bus_sel, 0);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi_i = tx[i];
      repeat (6) @(negedge clk_i);
      rx[i] = miso_o;
      sck_i = 1'b1;
      repeat (6) @(negedge clk_i);
      sck_i = 1'b0;
    end
  endtask

  task automatic wait_rec(input int n);
    int t = 0;
    while (q_addr.size() < n && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (q_addr.size() < n) chk("cyc_wait", q_addr.size(), n);
  endtask

  // one full frame; data bytes for writes come from fd[]
  task automatic run_frame(input bit w, input logic [1:0] sel,
                           input logic [5:0] a, input int n);
    logic [7:0] rx;
    int ne;
    clr();
    cs_n_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("oe_on", miso_oe, 1);
    spi_bits({w, 5'($urandom), sel}, 8, rx);
    spi_bits({2'b00, a}, 8, rx);
    if (!w) wait_rec(1);
    for (int k = 0; k < n; k++) begin
      spi_bits(w ? fd[k] : 8'($urandom), 8, rx);
      if (!w) chk("miso", rx, mem[sel][6'(a + k)]);
      wait_rec(w ? k + 1 : k + 2);
    end
    repeat (4) @(negedge clk_i);
    cs_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("halt_off", halt_req, 0);
    chk("oe_off", miso_oe, 0);
    ne = w ? n : n + 1;
    chk("ncyc", q_addr.size(), ne);
    for (int k = 0; k < ne && k < q_addr.size(); k++) begin
      chk("addr", q_addr[k], 6'(a + k));
      chk("sel", q_sel[k], 4'b0001 << sel);
      chk("we", q_we[k], w);
      chk("data", q_data[k], w ? fd[k] : 8'h00);
      chk("len", q_len[k], 2);
      chk("stable", q_stab[k], 1);
    end
    if (ack_dly && q_h.size() > 0) chk("ackwait", q_h[0] >= 20, 1);
    chk("viol", viol, 0);
  endtask

  logic [7:0] rx;
  bit         rw;
  logic [1:0] rsel;
  logic [5:0] ra;
  int         rn;
  int         t;

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 64; a++)
        mem[s][a] = 8'($urandom);
    mem[3][16] = 8'h3C;
    mem[3][17] = 8'h7E;

    repeat (5) @(negedge clk_i);
    chk_rst("rst0");
    rst_n = 1'b1;
    repeat (5) @(negedge clk_i);
    chk_rst("rst1");

    fd[0] = 8'hA5;
    run_frame(1'b1, 2'd1, 6'h05, 1);

    run_frame(1'b0, 2'd3, 6'h10, 2);

    for (int k = 0; k < 3; k++) fd[k] = 8'($urandom);
    run_frame(1'b1, 2'd2, 6'h3E, 3);

    ack_dly = 1'b1;
    fd[0] = 8'h5C;
    fd[1] = 8'hC3;
    run_frame(1'b1, 2'd0, 6'h21, 2);
    ack_dly = 1'b0;

    clr();
    cs_n_i = 1'b0;
    repeat (8) @(negedge clk_i);
    spi_bits(8'h81, 8, rx);
    spi_bits(8'h05, 4, rx);
    repeat (4) @(negedge clk_i);
    cs_n_i = 1'b1;
    repeat (60) @(negedge clk_i);
    chk("part_ncyc", q_addr.size(), 0);
    chk("part_halt", halt_req, 0);

    for (int r = 0; r < 10; r++) begin
      rw   = 1'($urandom);
      rsel = 2'($urandom);
      ra   = $urandom_range(0, 1) ? 6'(60 + $urandom_range(0, 3))
                                  : 6'($urandom);
      rn   = $urandom_range(1, 3);
      ack_dly = 1'($urandom);
      for (int k = 0; k < 4; k++) fd[k] = 8'($urandom);
      run_frame(rw, rsel, ra, rn);
    end

    ack_dly = 1'b1;
    cs_n_i = 1'b0;
    repeat (8) @(negedge clk_i);
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h5A, 8, rx);
    t = 0;
    while (!bus_cyc && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    chk("rst_cyc_seen", bus_cyc, 1);
    rst_n = 1'b0;
    @(negedge clk_i);
    chk_rst("rst_mid");
    cs_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    rst_n = 1'b1;
    ack_dly = 1'b0;
    repeat (5) @(negedge clk_i);
    chk_rst("rst_post");

    fd[0] = 8'h96;
    run_frame(1'b1, 2'd3, 6'h0A, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
